// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
package keypad_pkg;

    localparam int KEY_W  = 4;
    localparam int N_ROWS = 4;
    localparam int N_COLS = 4;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    function automatic logic [KEY_W-1:0] encode_key(input logic [1:0] row_idx,
                                                    input logic [1:0] col_idx);
        return {row_idx, col_idx};
    endfunction

    // Lowest set row wins when several keys share the sampled column.
    function automatic logic [1:0] lowest_row(input logic [N_ROWS-1:0] rows);
        logic [1:0] idx;
        idx = '0;
        for (int i = N_ROWS - 1; i >= 0; i--) begin
            if (rows[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad matrix lines plus the decoded key outputs; master is the scanner side.
interface keypad_scanner_if;
    import keypad_pkg::*;

    logic [N_ROWS-1:0] row_in;
    logic [N_COLS-1:0] col_out;
    logic [KEY_W-1:0]  code;
    logic              key_valid;
    logic              key_held;

    modport master (input row_in, output col_out, code, key_valid, key_held);
    modport slave  (output row_in, input col_out, code, key_valid, key_held);
endinterface

// File: rtl/keypad_scanner_row_sync.sv
// Purpose: 2-flop synchroniser for the asynchronous keypad row lines.
// Latency: 2 cycles from d to q.
// Backpressure: none, free-running.
module row_sync #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Purpose: scan a 4x4 keypad one column at a time, debounce, report the key code.
// Latency: DEBOUNCE_CNT+1 cycles from the column sample cycle to key_valid.
// Backpressure: none; key_valid is a one-cycle strobe, code holds until the next key.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 50000
) (
    input  logic              clk,
    input  logic              rst,
    keypad_scanner_if.master  kp
);

    localparam int DW = $clog2(SCAN_DIV) + 1;
    localparam int CW = $clog2(DEBOUNCE_CNT) + 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CNT - 1);
    localparam logic [CW-1:0] CNT_MAX    = '1;

    logic [N_ROWS-1:0] row_s;
    state_t            state_q, state_d;
    logic [DW-1:0]     dwell_q, dwell_d;
    logic [CW-1:0]     cnt_q,   cnt_d;
    logic [1:0]        col_q,   col_d;
    logic [1:0]        row_q,   row_d;
    logic [KEY_W-1:0]  code_q,  code_d;
    logic              valid_q, valid_d;
    logic              held_q,  held_d;
    logic              row_hit;
    logic [CW-1:0]     cnt_inc;

    row_sync #(.W(N_ROWS)) u_row_sync (
        .clk (clk),
        .rst (rst),
        .d   (kp.row_in),
        .q   (row_s)
    );

    assign row_hit = row_s[row_q];
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SCAN;
            dwell_q <= '0;
            cnt_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
            row_q   <= row_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            held_q  <= held_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dwell_d = dwell_q;
        cnt_d   = cnt_q;
        col_d   = col_q;
        row_d   = row_q;
        code_d  = code_q;
        valid_d = 1'b0;
        held_d  = held_q;
        case (state_q)
            SCAN: begin
                if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    if (|row_s) begin
                        row_d   = lowest_row(row_s);
                        cnt_d   = '0;
                        state_d = DEBOUNCE;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (!row_hit) begin
                    col_d   = col_q + 2'd1;
                    dwell_d = '0;
                    state_d = SCAN;
                end else if (cnt_q == CNT_LAST) begin
                    code_d  = encode_key(row_q, col_q);
                    valid_d = 1'b1;
                    held_d  = 1'b1;
                    state_d = HELD;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            HELD: begin
                // Column stays frozen, so other keys cannot disturb the held one.
                if (!row_hit) begin
                    cnt_d   = '0;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (row_hit) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    held_d  = 1'b0;
                    col_d   = col_q + 2'd1;
                    dwell_d = '0;
                    state_d = SCAN;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    assign kp.col_out   = N_COLS'(1) << col_q;
    assign kp.code      = code_q;
    assign kp.key_valid = valid_q;
    assign kp.key_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;
    import keypad_pkg::*;

    localparam int SD = 4;
    localparam int DC = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    keypad_scanner_if kp();

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DC)) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp)
    );

    int errors = 0;
    int checks = 0;
    int vcount = 0;
    bit run_chk = 1'b0;

    // Behavioural reference: row lines seen through a 2-deep delay queue,
    // column timing from absolute cycle numbers, debounce as run lengths.
    localparam int M_SCAN = 0, M_DEB = 1, M_HELD = 2, M_REL = 3;
    logic [3:0] m_pipe[$];
    logic [3:0] m_rs;
    int m_mode, m_col, m_col_start, m_row, m_run, m_code, m_cyc;
    bit m_valid, m_held;

    function automatic int lowest(input logic [3:0] r);
        for (int i = 0; i < 4; i++) if (r[i]) return i;
        return 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pipe = '{4'd0, 4'd0};
            m_mode = M_SCAN; m_col = 0; m_col_start = 0; m_cyc = 0;
            m_row = 0; m_run = 0; m_code = 0; m_valid = 0; m_held = 0;
        end else begin
            m_rs = m_pipe.pop_front();
            m_pipe.push_back(kp.row_in);
            m_valid = 0;
            case (m_mode)
                M_SCAN: if (m_cyc - m_col_start == SD - 1) begin
                    if (m_rs != 0) begin
                        m_row = lowest(m_rs); m_run = 0; m_mode = M_DEB;
                    end else begin
                        m_col = (m_col + 1) % 4; m_col_start = m_cyc + 1;
                    end
                end
                M_DEB: if (m_rs[m_row]) begin
                    m_run++;
                    if (m_run == DC) begin
                        m_code = m_row * 4 + m_col; m_valid = 1; m_held = 1; m_mode = M_HELD;
                    end
                end else begin
                    m_col = (m_col + 1) % 4; m_col_start = m_cyc + 1; m_mode = M_SCAN;
                end
                M_HELD: if (!m_rs[m_row]) begin
                    m_run = 0; m_mode = M_REL;
                end
                default: if (m_rs[m_row]) begin
                    m_run = 0;
                end else begin
                    m_run++;
                    if (m_run == DC) begin
                        m_held = 0; m_col = (m_col + 1) % 4; m_col_start = m_cyc + 1; m_mode = M_SCAN;
                    end
                end
            endcase
            m_cyc++;
        end
    end

    always @(negedge clk) begin
        if (run_chk) begin
            checks++;
            if (kp.col_out !== 4'(1 << m_col) || kp.code !== 4'(m_code) ||
                kp.key_valid !== m_valid || kp.key_held !== m_held) begin
                errors++;
                $display("FAIL model t=%0t got col=%b code=%0d vld=%b held=%b, expected col=%b code=%0d vld=%b held=%b",
                         $time, kp.col_out, kp.code, kp.key_valid, kp.key_held,
                         4'(1 << m_col), m_code, m_valid, m_held);
            end
            if (kp.key_valid === 1'b1) vcount++;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_col"},   kp.col_out, 1);
        chk({tag, "_code"},  kp.code, 0);
        chk({tag, "_valid"}, kp.key_valid, 0);
        chk({tag, "_held"},  kp.key_held, 0);
    endtask

    task automatic rotation(input string tag);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk({tag, "_rotate"}, kp.col_out, 1 << ((i / 4) % 4));
        end
    endtask

    task automatic do_reset(input string tag);
        kp.row_in = '0;
        rst = 1'b1;
        #1;
        check_reset(tag);
        tick(1);
        rst = 1'b0;
        rotation(tag);
    endtask

    // Waits for the column to be freshly selected so a press starts at dwell 0.
    task automatic wait_col(input int c);
        int n = 0;
        while (kp.col_out == 4'(1 << c) && n < 80) begin tick(1); n++; end
        while (kp.col_out != 4'(1 << c) && n < 80) begin tick(1); n++; end
        chk("wait_col_in_time", int'(n < 80), 1);
    endtask

    typedef struct {
        logic [3:0] rows;
        int         col;
        int         hold;
        logic [3:0] extra;
        int         exp_code;
        int         exp_vld;
    } vec_t;

    vec_t tbl[5];

    task automatic apply_vec(input vec_t v);
        int v0 = vcount;
        int n = 0;
        wait_col(v.col);
        kp.row_in = v.rows;
        for (int i = 0; i < v.hold; i++) begin
            tick(1);
            if (i == 20) kp.row_in = v.rows | v.extra;
        end
        if (v.exp_vld > 0) begin
            chk("frozen_col", kp.col_out, 1 << v.col);
            chk("held_high", kp.key_held, 1);
        end
        kp.row_in = '0;
        if (v.exp_vld > 0) begin
            while (kp.key_held && n < 100) begin tick(1); n++; end
            chk("release_in_time", int'(n < 100), 1);
            tick(2);
        end else begin
            while (kp.col_out == 4'(1 << v.col) && n < 40) begin tick(1); n++; end
            chk("scan_resumes_next_col", kp.col_out, 1 << ((v.col + 1) % 4));
        end
        chk("valid_count", vcount - v0, v.exp_vld);
        chk("code_after", kp.code, v.exp_code);
    endtask

    initial begin
        int n;
        int v0;
        // rows, col, hold, extra rows added mid-hold, expected code, expected strobes
        tbl[0] = '{4'b0100, 2, 40, 4'b0000, 10, 1};  // clean press row2/col2
        tbl[1] = '{4'b0010, 1,  5, 4'b0000, 10, 0};  // short glitch
        tbl[2] = '{4'b1001, 1, 40, 4'b0100,  1, 1};  // two keys, extra row while held
        tbl[3] = '{4'b0001, 3, 40, 4'b0000,  3, 1};
        tbl[4] = '{4'b1000, 0,  3, 4'b0000,  3, 0};

        kp.row_in = '0;
        #1 rst = 1'b1;
        run_chk = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        check_reset("init");
        rst = 1'b0;
        rotation("init");
        tick(1);

        for (int i = 0; i < 5; i++) apply_vec(tbl[i]);

        // Bouncing release of row3/col3
        wait_col(3);
        kp.row_in = 4'b1000;
        n = 0;
        while (!kp.key_held && n < 60) begin tick(1); n++; end
        chk("bounce_press_in_time", int'(n < 60), 1);
        chk("bounce_code", kp.code, 15);
        tick(5);
        v0 = vcount;
        for (int i = 0; i < 3; i++) begin
            kp.row_in = '0;      tick(2);
            kp.row_in = 4'b1000; tick(1);
        end
        kp.row_in = '0;
        n = 0;
        while (kp.key_held && n < 40) begin tick(1); n++; end
        chk("bounce_fall_cycles", n, 10);
        chk("bounce_no_second_valid", vcount - v0, 0);
        tick(3);

        // Reset partway through a debounce
        wait_col(0);
        kp.row_in = 4'b0001;
        v0 = vcount;
        tick(7);
        do_reset("rst_debounce");
        chk("rst_debounce_no_valid", vcount - v0, 0);
        tick(1);

        // Reset while a key is held
        wait_col(2);
        kp.row_in = 4'b0100;
        n = 0;
        while (!kp.key_held && n < 60) begin tick(1); n++; end
        chk("midhold_press_in_time", int'(n < 60), 1);
        tick(3);
        do_reset("rst_midhold");
        tick(1);

        // Random traffic against the reference model
        for (int s = 0; s < 80; s++) begin
            if ($urandom_range(0, 1) == 0) kp.row_in = '0;
            else kp.row_in = 4'($urandom_range(1, 15));
            tick($urandom_range(1, 40));
        end
        kp.row_in = '0;
        tick(40);
        kp.row_in = 4'($urandom_range(1, 15));
        tick(9);
        do_reset("rst_random");

        run_chk = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
